sync_fifo_param: RTL
====================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the team's synchronous FIFO.
//  Adds: any DEPTH (not only powers of 2), selectable standard/FWFT read mode,
//  runtime-programmable almost-full/almost-empty thresholds, fill-level output,
//  synchronous flush and sticky error flags. Sits between producer/consumer stages.
// PARAMETERS
//  FIFO_WIDTH   16  data word width in bits (>=1)
//  FIFO_DEPTH    8  number of entries (>=2, any integer)
//  FWFT          0  0 = standard (data 1 cycle after rd_en); 1 = first-word-fall-through
//  CNT_W  $clog2(FIFO_DEPTH+1)  width of level and threshold ports (localparam)
// PORTS
//  clk          in   1           clock, all logic on rising edge
//  rst          in   1           synchronous reset, active-high
//  flush        in   1           synchronous clear of contents (pointers/level)
//  wr_en        in   1           write request
//  data_in      in   FIFO_WIDTH  write data
//  rd_en        in   1           read request (FWFT: pop current head)
//  data_out     out  FIFO_WIDTH  read data
//  rd_valid     out  1           data_out holds valid read data
//  af_thresh    in   CNT_W       almost-full threshold
//  ae_thresh    in   CNT_W       almost-empty threshold
//  level        out  CNT_W       current entry count, 0..FIFO_DEPTH
//  full/empty   out  1 each      level==FIFO_DEPTH / level==0 (combinational from level)
//  almostfull   out  1           level >= af_thresh
//  almostempty  out  1           level <= ae_thresh
//  wr_ack       out  1           registered: write accepted last cycle
//  overflow     out  1           registered: write rejected (full) last cycle
//  underflow    out  1           registered: read rejected (empty) last cycle
//  err_sticky   out  2           {overflow_seen, underflow_seen}; cleared by rst or flush
// BEHAVIOUR
//  - Reset (rst=1 at edge): wr_ptr=rd_ptr=level=0; wr_ack, overflow, underflow,
//    rd_valid, err_sticky, data_out = 0; empty=1, full=0; memory not cleared.
//  - wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty. Flags decided on pre-edge level.
//  - Simultaneous wr/rd: full -> read only, overflow=1; empty -> write only, underflow=1;
//    otherwise both accepted, level unchanged.
//  - level_next = level + wr_acc - rd_acc; never exceeds FIFO_DEPTH, never below 0.
//  - Pointers wrap: ptr==FIFO_DEPTH-1 -> 0 on accept (explicit compare, not bit overflow).
//  - Standard mode: on rd_acc, data_out <= mem[rd_ptr], rd_valid<=1 next cycle; else
//    rd_valid<=0, data_out holds last value. Read latency 1 cycle.
//  - FWFT mode: data_out = mem[rd_ptr] combinational, rd_valid = ~empty; rd_acc pops.
//    Write to empty FIFO visible on data_out the cycle after the write edge.
//  - flush (rst has priority): pointers/level=0, wr_ack/overflow/underflow=0,
//    err_sticky=0, rd_valid=0; wr_en/rd_en in that cycle ignored.
//  - af_thresh/ae_thresh sampled combinationally; values > FIFO_DEPTH: almostfull never
//    asserts / almostempty always asserts. No restriction on af_thresh<=ae_thresh.
//  - Reset or flush mid-burst: data in flight discarded; next write lands in entry 0.
// STRUCTURE
//  - fifo_pkg: fifo_mode_e {FIFO_STD, FIFO_FWFT}, status struct {wr_ack,overflow,underflow}.
//  - Sub-module fifo_ram: FIFO_WIDTH x FIFO_DEPTH, 1 sync write port, 1 async read port.
//  - Top holds pointer/level control, flag logic, read-output register (std mode).
//  - SIM-guarded assertions: level<=FIFO_DEPTH, ptrs<FIFO_DEPTH, flag/level consistency.
// TESTING (WIDTH=16, DEPTH=5, both FWFT=0 and 1)
//  1 Write 0xA000..0xA004 then 6th write -> full=1, level=5, 6th cycle wr_ack=0/overflow=1,
//    err_sticky[1]=1; 5 reads return A000..A004 in order, then empty=1.
//  2 Read when empty -> underflow=1 next cycle, level stays 0, rd_valid=0, err_sticky[0]=1.
//  3 Fill to 5, assert wr_en&rd_en -> level 4, overflow=1, A000 read; at level 0 same ->
//    level 1, underflow=1.
//  4 Write/read 12 words interleaved with level held at 3 -> ptrs wrap 4->0, data order
//    intact, no flags.
//  5 af_thresh=4, ae_thresh=1: level 0->5 gives almostempty at 0,1; almostfull at 4,5.
//  6 Level 3, pulse flush with wr_en=1 -> level 0, empty=1, err_sticky=0, next write at
//    entry 0; rst mid-write likewise clears all outputs to reset values.

Source files
------------

// File: rtl/sync_fifo_param_pkg.sv
// Shared types for the parametrised synchronous FIFO: read-mode selector and
// the per-cycle status bundle reported back to the producer.
package sync_fifo_param_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  typedef struct packed {
    logic wr_ack;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage : sync_fifo_param_pkg

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of the synchronous FIFO; master drives requests and
// thresholds, slave (the FIFO) returns data, level and flags.
interface sync_fifo_param_if #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
) ();
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  flush;
  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic [CNT_W-1:0]      af_thresh;
  logic [CNT_W-1:0]      ae_thresh;
  logic [CNT_W-1:0]      level;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic [1:0]            err_sticky;

  modport master (
    output flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
    input  data_out, rd_valid, level, full, empty, almostfull, almostempty,
           wr_ack, overflow, underflow, err_sticky
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
    output data_out, rd_valid, level, full, empty, almostfull, almostempty,
           wr_ack, overflow, underflow, err_sticky
  );

endinterface : sync_fifo_param_if

// File: rtl/sync_fifo_param_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are never reset.
module sync_fifo_param_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : sync_fifo_param_ram

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: any depth, standard or first-word-fall-through
// read, programmable almost flags, fill level, synchronous flush, sticky errors.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FWFT       = 0
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam fifo_mode_e  MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      level_q, level_d;
  fifo_status_t          status_q, status_d;
  logic [1:0]            err_q, err_d;
  logic                  full_c, empty_c, wr_acc_c, rd_acc_c;
  logic [FIFO_WIDTH-1:0] ram_rdata_c;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_c   = (level_q == CNT_W'(FIFO_DEPTH));
  assign empty_c  = (level_q == '0);
  assign wr_acc_c = bus.wr_en & ~full_c & ~bus.flush;
  assign rd_acc_c = bus.rd_en & ~empty_c & ~bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    status_d = '0;
    err_d    = err_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      err_d    = '0;
    end else begin
      if (wr_acc_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc_c) rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({wr_acc_c, rd_acc_c})
        2'b10:   level_d = level_q + CNT_W'(1);
        2'b01:   level_d = level_q - CNT_W'(1);
        default: level_d = level_q;
      endcase
      status_d.wr_ack    = wr_acc_c;
      status_d.overflow  = bus.wr_en & full_c;
      status_d.underflow = bus.rd_en & empty_c;
      err_d              = err_q | {status_d.overflow, status_d.underflow};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      status_q <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      status_q <= status_d;
      err_q    <= err_d;
    end
  end

  sync_fifo_param_ram #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata_c)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [FIFO_WIDTH-1:0] dout_q, dout_d;
    logic                  rvalid_q, rvalid_d;

    // Registered read port; data_out keeps its last value between reads.
    always_comb begin
      dout_d   = dout_q;
      rvalid_d = rd_acc_c;
      if (rd_acc_c) dout_d = ram_rdata_c;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q   <= '0;
        rvalid_q <= 1'b0;
      end else begin
        dout_q   <= dout_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign bus.data_out = dout_q;
    assign bus.rd_valid = rvalid_q;
  end else begin : g_fwft
    // Head is shown directly; masked to zero while empty so stale memory never leaks.
    assign bus.data_out = empty_c ? '0 : ram_rdata_c;
    assign bus.rd_valid = ~empty_c;
  end

  assign bus.level       = level_q;
  assign bus.full        = full_c;
  assign bus.empty       = empty_c;
  assign bus.almostfull  = (level_q >= bus.af_thresh);
  assign bus.almostempty = (level_q <= bus.ae_thresh);
  assign bus.wr_ack      = status_q.wr_ack;
  assign bus.overflow    = status_q.overflow;
  assign bus.underflow   = status_q.underflow;
  assign bus.err_sticky  = err_q;

`ifdef SIM
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (level_q <= CNT_W'(FIFO_DEPTH));
      assert (32'(wr_ptr_q) < FIFO_DEPTH);
      assert (32'(rd_ptr_q) < FIFO_DEPTH);
      assert (!(full_c && empty_c));
      assert (!(status_q.wr_ack && status_q.overflow));
    end
  end
`endif

endmodule : sync_fifo_param
